wb_imem_loader: RTL and testbench

//  Wishbone initiator that streams a program image into the instruction SRAM behind the vsdmemsoc responder.

---
 rtl/vsdmemsoc_pkg.sv | 17 +
 rtl/wb_master_port.sv | 67 ++++++
 rtl/wb_imem_loader.sv | 149 ++++++++++++++
 tb/tb_wb_imem_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsdmemsoc_pkg.sv
// Shared types and constants for the vsdmemsoc instruction-memory loader.
package vsdmemsoc_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned IDX_W   = 9;
   localparam logic [3:0]  SEL_ALL = 4'b1111;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StWrite,
      StVerify,
      StDone,
      StError
   } loader_state_e;

endpackage

// File: rtl/wb_master_port.sv
// Classic Wishbone single-transfer initiator: launches a cycle on go_i and holds it until ack
// or until ACK_TIMEOUT cycles pass without one.
module wb_master_port
   import vsdmemsoc_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              go_i,
   input  logic              go_we_i,
   input  logic [WORD_W-1:0] go_adr_i,
   input  logic [WORD_W-1:0] go_dat_i,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [WORD_W-1:0] wbm_adr_o,
   output logic [WORD_W-1:0] wbm_dat_o,
   input  logic              wbm_ack_i,
   output logic              ack_o,
   output logic              timeout_o
);

   localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

   logic              cyc_q;
   logic              we_q;
   logic [WORD_W-1:0] adr_q;
   logic [WORD_W-1:0] dat_q;
   logic [CntW-1:0]   cnt_q;

   assign ack_o     = cyc_q & wbm_ack_i;
   assign timeout_o = cyc_q & ~wbm_ack_i & (cnt_q == CntW'(ACK_TIMEOUT - 1));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         adr_q <= '0;
         dat_q <= '0;
         cnt_q <= '0;
      end else if (go_i) begin
         cyc_q <= 1'b1;
         we_q  <= go_we_i;
         adr_q <= go_adr_i;
         dat_q <= go_dat_i;
         cnt_q <= '0;
      end else if (cyc_q) begin
         // Drop on the ack edge itself so a single-cycle ack is never re-strobed.
         if (ack_o || timeout_o) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = cyc_q ? SEL_ALL : 4'b0000;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

endmodule

// File: rtl/wb_imem_loader.sv
// Streams a byte image into instruction SRAM as little-endian 32-bit Wishbone writes.
// Define LOADER_READBACK_EN to read back and compare every word after it is written.
module wb_imem_loader
   import vsdmemsoc_pkg::*;
#(
   parameter logic [WORD_W-1:0] BASE_ADDRESS = 32'h3000_0000,
   parameter int unsigned       MAX_WORDS    = 256,
   parameter int unsigned       ACK_TIMEOUT  = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start,
   input  logic [IDX_W-1:0]  word_count,
   input  logic [7:0]        s_byte,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [WORD_W-1:0] wbm_adr_o,
   output logic [WORD_W-1:0] wbm_dat_o,
   input  logic [WORD_W-1:0] wbm_dat_i,
   input  logic              wbm_ack_i,
   output logic              busy,
   output logic              done,
   output logic              err
);

   loader_state_e     state_q;
   logic [IDX_W-1:0]  count_q;
   logic [IDX_W-1:0]  idx_q;
   logic [1:0]        byte_idx_q;
   logic [WORD_W-1:0] word_q;

   logic              go;
   logic              go_we;
   logic [WORD_W-1:0] go_adr;
   logic [WORD_W-1:0] go_dat;
   logic              ack;
   logic              timeout;
   logic [IDX_W-1:0]  idx_inc;

`ifdef LOADER_READBACK_EN
   logic rd_issued_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^wbm_dat_i;
`endif

   always_comb begin
      idx_inc = idx_q + IDX_W'(1);
      go_adr  = BASE_ADDRESS + {{(WORD_W-IDX_W-2){1'b0}}, idx_q, 2'b00};
      go_dat  = {s_byte, word_q[23:0]};
      go_we   = 1'b1;
      go      = (state_q == StCollect) && s_valid && (byte_idx_q == 2'd3);
`ifdef LOADER_READBACK_EN
      if (state_q == StVerify && !rd_issued_q) begin
         go     = 1'b1;
         go_we  = 1'b0;
         go_dat = word_q;
      end
`endif
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         count_q    <= '0;
         idx_q      <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
`ifdef LOADER_READBACK_EN
         rd_issued_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle, StDone, StError: begin
               if (start) begin
                  idx_q      <= '0;
                  byte_idx_q <= '0;
                  count_q    <= (32'(word_count) > MAX_WORDS) ? IDX_W'(MAX_WORDS) : word_count;
                  state_q    <= (word_count == '0) ? StDone : StCollect;
               end
            end
            StCollect: begin
               if (s_valid) begin
                  word_q[{byte_idx_q, 3'b000} +: 8] <= s_byte;
                  byte_idx_q <= byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) state_q <= StWrite;
               end
            end
            StWrite: begin
               if (timeout) begin
                  state_q <= StError;
               end else if (ack) begin
                  idx_q <= idx_inc;
`ifdef LOADER_READBACK_EN
                  state_q     <= StVerify;
                  rd_issued_q <= 1'b0;
`else
                  state_q <= (idx_inc == count_q) ? StDone : StCollect;
`endif
               end
            end
`ifdef LOADER_READBACK_EN
            StVerify: begin
               if (!rd_issued_q) begin
                  rd_issued_q <= 1'b1;
               end else if (timeout) begin
                  state_q <= StError;
               end else if (ack) begin
                  // idx_q was already advanced when the write was acknowledged.
                  if (wbm_dat_i != word_q) state_q <= StError;
                  else state_q <= (idx_q == count_q) ? StDone : StCollect;
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

   assign s_ready = (state_q == StCollect);
   assign busy    = (state_q == StCollect) || (state_q == StWrite) || (state_q == StVerify);
   assign done    = (state_q == StDone);
   assign err     = (state_q == StError);

   wb_master_port #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_port (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .go_i      (go),
      .go_we_i   (go_we),
      .go_adr_i  (go_adr),
      .go_dat_i  (go_dat),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (wbm_ack_i),
      .ack_o     (ack),
      .timeout_o (timeout)
   );

endmodule

// File: tb/tb_wb_imem_loader.sv
// Bench for wb_imem_loader: Wishbone slave model with programmable ack latency plus an
// expected-write list built directly from the byte stream.
module tb_wb_imem_loader;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          TOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  word_count;
   logic [7:0]  s_byte;
   logic        s_valid;
   logic        s_ready;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, rdata;
   logic        ack;
   logic        busy, done, err;

   wb_imem_loader dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .start      (start),
      .word_count (word_count),
      .s_byte     (s_byte),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .wbm_cyc_o  (cyc),
      .wbm_stb_o  (stb),
      .wbm_we_o   (we),
      .wbm_sel_o  (sel),
      .wbm_adr_o  (adr),
      .wbm_dat_o  (dat_o),
      .wbm_dat_i  (rdata),
      .wbm_ack_i  (ack),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Slave model state
   int          ack_delay = 1;
   bit          withhold  = 1'b0;
   bit          corrupt   = 1'b0;
   int          wcnt;
   bit          hold_v;
   bit          after_ack;
   logic [31:0] hold_adr, hold_dat;
   logic        hold_we;
   int          cyc_seen = 0;
   logic [31:0] mem [256];
   logic [31:0] wr_adr_q[$];
   logic [31:0] wr_dat_q[$];
   logic [31:0] exp_adr_q[$];
   logic [31:0] exp_dat_q[$];

   function automatic logic [7:0] widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off[9:2];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         ack       <= 1'b0;
         rdata     <= '0;
         wcnt      <= 0;
         hold_v    <= 1'b0;
         after_ack <= 1'b0;
      end else begin
         if (after_ack) check("cyc_drop_after_ack", {31'b0, cyc}, 32'd0);
         after_ack <= 1'b0;
         if (cyc && stb) begin
            cyc_seen <= cyc_seen + 1;
            if (!hold_v) begin
               hold_v   <= 1'b1;
               hold_adr <= adr;
               hold_dat <= dat_o;
               hold_we  <= we;
            end else begin
               check("adr_stable", adr, hold_adr);
               check("dat_stable", dat_o, hold_dat);
               check("we_stable", {31'b0, we}, {31'b0, hold_we});
            end
            if (ack) begin
               if (we) begin
                  wr_adr_q.push_back(adr);
                  wr_dat_q.push_back(dat_o);
                  mem[widx(adr)] <= dat_o;
               end
               ack       <= 1'b0;
               wcnt      <= 0;
               hold_v    <= 1'b0;
               after_ack <= 1'b1;
            end else if (!withhold) begin
               if (wcnt + 1 >= ack_delay) begin
                  ack <= 1'b1;
                  if (corrupt && mem[widx(adr)] == 32'h1234_5678) rdata <= 32'h1234_5679;
                  else rdata <= mem[widx(adr)];
               end else begin
                  wcnt <= wcnt + 1;
               end
            end
         end else begin
            ack    <= 1'b0;
            wcnt   <= 0;
            hold_v <= 1'b0;
         end
      end
   end

   // Bus-level properties checked while a cycle is open
   always @(negedge clk) begin
      if (!rst && cyc) begin
         check("sel_all", {28'b0, sel}, 32'hF);
         check("s_ready_low_in_cycle", {31'b0, s_ready}, 32'd0);
`ifndef LOADER_READBACK_EN
         check("we_high", {31'b0, we}, 32'd1);
`endif
      end
   end

   task automatic start_load(input logic [8:0] wc);
      word_count = wc;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_byte  = b;
      n = 0;
      while (!s_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check("s_ready_wait", {31'b0, s_ready}, 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_end(input int budget);
      int n;
      n = 0;
      while (!(done || err) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check("end_wait", {30'b0, done, err}, 32'd2);
   endtask

   task automatic clear_lists();
      wr_adr_q.delete();
      wr_dat_q.delete();
      exp_adr_q.delete();
      exp_dat_q.delete();
   endtask

   // Push a random word onto the expected list and stream it LSB first.
   task automatic send_word(input logic [31:0] w, input int max_gap);
      logic [31:0] wv;
      wv = w;
      exp_adr_q.push_back(BASE + 32'(exp_adr_q.size()) * 32'd4);
      exp_dat_q.push_back(wv);
      for (int k = 0; k < 4; k++) send_byte(wv[8*k +: 8], int'($urandom_range(0, max_gap)));
   endtask

   task automatic check_writes();
      check("write_count", 32'(wr_adr_q.size()), 32'(exp_adr_q.size()));
      for (int i = 0; i < exp_adr_q.size() && i < wr_adr_q.size(); i++) begin
         check("write_adr", wr_adr_q[i], exp_adr_q[i]);
         check("write_dat", wr_dat_q[i], exp_dat_q[i]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, k, n;
      rst = 1'b1; start = 1'b0; word_count = '0; s_byte = '0; s_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cyc", {31'b0, cyc}, 0);
      check("rst_stb", {31'b0, stb}, 0);
      check("rst_we", {31'b0, we}, 0);
      check("rst_sel", {28'b0, sel}, 0);
      check("rst_adr", adr, 0);
      check("rst_dat", dat_o, 0);
      check("rst_s_ready", {31'b0, s_ready}, 0);
      check("rst_flags", {29'b0, busy, done, err}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Zero-length load completes on the next edge without touching the bus
      c0 = cyc_seen;
      start_load(9'd0);
      check("zero_flags", {29'b0, busy, done, err}, 32'b010);
      for (int i = 0; i < 3; i++) begin
         check("zero_s_ready", {31'b0, s_ready}, 0);
         @(negedge clk);
      end
      check("zero_no_cycle", 32'(cyc_seen), 32'(c0));

      // Directed two-word load
      clear_lists();
      ack_delay = 1;
      start_load(9'd2);
      check("start_flags", {28'b0, s_ready, busy, done, err}, 32'b1100);
      send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      check("write_next_cycle", {30'b0, cyc, s_ready}, 32'b10);
      check("first_adr", adr, 32'h3000_0000);
      check("first_dat", dat_o, 32'h1234_5678);
      send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
      s_valid = 1'b0;
      exp_adr_q.push_back(32'h3000_0000); exp_dat_q.push_back(32'h1234_5678);
      exp_adr_q.push_back(32'h3000_0004); exp_dat_q.push_back(32'hDEAD_BEEF);
      wait_end(200);
      check("dir_flags", {29'b0, busy, done, err}, 32'b010);
      check_writes();

      // Randomized loads with random byte gaps and ack latency
      for (int it = 0; it < 4; it++) begin
         clear_lists();
         n = int'($urandom_range(1, 6));
         ack_delay = int'($urandom_range(1, 4));
         start_load(9'(n));
         for (int w = 0; w < n; w++) send_word($urandom, 2);
         s_valid = 1'b0;
         wait_end(600);
         check("rand_flags", {29'b0, busy, done, err}, 32'b010);
         check_writes();
      end

      // Oversized count is clamped to the SRAM depth
      clear_lists();
      ack_delay = 1;
      start_load(9'd300);
      for (int w = 0; w < 256; w++) send_word($urandom, 0);
      s_valid = 1'b0;
      wait_end(100);
      check("clamp_flags", {29'b0, busy, done, err}, 32'b010);
      check_writes();

      // Withheld ack: error exactly TOUT cycles after the strobe rises
      clear_lists();
      withhold = 1'b1;
      start_load(9'd1);
      check("rearm_after_done", {29'b0, busy, done, err}, 32'b100);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      s_valid = 1'b0;
      check("timeout_stb_up", {31'b0, stb}, 1);
      k = 0;
      while (!err && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("timeout_cycles", 32'(k), 32'(TOUT));
      check("timeout_bus", {30'b0, cyc, stb}, 0);
      check("timeout_flags", {29'b0, busy, done, err}, 32'b001);
      check_writes();
      withhold = 1'b0;

      // Stream stalls with a 3-cycle ack; error cleared on re-arm
      clear_lists();
      ack_delay = 3;
      start_load(9'd2);
      check("rearm_after_err", {29'b0, busy, done, err}, 32'b100);
      for (int w = 0; w < 2; w++) begin
         logic [31:0] wv;
         wv = $urandom;
         exp_adr_q.push_back(BASE + 32'(w) * 32'd4);
         exp_dat_q.push_back(wv);
         for (int b = 0; b < 4; b++) send_byte(wv[8*b +: 8], b % 2);
      end
      s_valid = 1'b0;
      wait_end(200);
      check("toggle_flags", {29'b0, busy, done, err}, 32'b010);
      check_writes();

      // Reset with a write strobe pending, then reload from word 0
      withhold = 1'b1;
      ack_delay = 1;
      start_load(9'd2);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
      s_valid = 1'b0;
      check("pre_reset_stb", {31'b0, stb}, 1);
      rst = 1'b1;
      @(negedge clk);
      check("reset_bus", {30'b0, cyc, stb}, 0);
      check("reset_adr", adr, 0);
      check("reset_dat", dat_o, 0);
      check("reset_sel", {28'b0, sel}, 0);
      check("reset_flags", {28'b0, s_ready, busy, done, err}, 0);
      rst = 1'b0;
      withhold = 1'b0;
      @(negedge clk);
      clear_lists();
      start_load(9'd1);
      send_word($urandom, 1);
      s_valid = 1'b0;
      wait_end(200);
      check("reload_flags", {29'b0, busy, done, err}, 32'b010);
      check_writes();

`ifdef LOADER_READBACK_EN
      // Corrupted readback stops the load after the first word
      clear_lists();
      corrupt = 1'b1;
      start_load(9'd2);
      send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
      s_valid = 1'b0;
      exp_adr_q.push_back(32'h3000_0000); exp_dat_q.push_back(32'h1234_5678);
      wait_end(200);
      check("readback_flags", {29'b0, busy, done, err}, 32'b001);
      repeat (5) @(negedge clk);
      check_writes();
      corrupt = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
